// File: rtl/vend_dispense.sv
// Output-side actuator sequencer for the vending machine: queues product/change
// strobes and runs the motor and coin hopper one request at a time under a timeout.
module vend_dispense #(
    parameter int TIMEOUT = 255,
    parameter int GAP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p,
    input  logic c,
    input  logic motor_done,
    input  logic hopper_ack,
    input  logic clr_fault,
    output logic motor_en,
    output logic coin_eject,
    output logic busy,
    output logic fault,
    output logic ovf
);

    typedef enum logic [2:0] {
        IDLE,
        MOTOR,
        COIN,
        GAP,
        FAULT
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT);
    localparam logic [2:0] GAP_LAST   = 3'(GAP_CYC - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] timer;
    logic [2:0] gap_cnt;
    logic [1:0] prod_cnt;
    logic [3:0] chg_cnt;
    logic       p_d;
    logic       c_d;
    logic       p_req;
    logic       c_req;
    logic       prod_take;
    logic       chg_take;

    assign p_req = p & ~p_d;
    assign c_req = c & ~c_d;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx  = state;
        prod_take = 1'b0;
        chg_take  = 1'b0;
        case (state)
            IDLE: begin
                if (prod_cnt != 2'd0) begin
                    state_nx  = MOTOR;
                    prod_take = 1'b1;
                end else if (chg_cnt != 4'd0) begin
                    state_nx = COIN;
                    chg_take = 1'b1;
                end
            end
            // Completion is checked before the timeout so a late done still counts as success.
            MOTOR: begin
                if (motor_done)                state_nx = GAP;
                else if (timer == TIMER_LAST)  state_nx = FAULT;
            end
            COIN: begin
                if (hopper_ack)                state_nx = GAP;
                else if (timer == TIMER_LAST)  state_nx = FAULT;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)       state_nx = IDLE;
            end
            FAULT: begin
                if (clr_fault)                 state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= 8'd0;
            gap_cnt    <= 3'd0;
            motor_en   <= 1'b0;
            coin_eject <= 1'b0;
        end else begin
            state      <= state_nx;
            // Drives are registered off the next state so they track the state flop exactly.
            motor_en   <= (state_nx == MOTOR);
            coin_eject <= (state_nx == COIN);
            if (state_nx != state) begin
                timer   <= 8'd0;
                gap_cnt <= 3'd0;
            end else if (state == MOTOR || state == COIN) begin
                timer   <= timer + 8'd1;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 3'd1;
            end
        end
    end

    // Request queues: a simultaneous arrival and service leaves the count untouched, even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_d      <= 1'b0;
            c_d      <= 1'b0;
            prod_cnt <= 2'd0;
            chg_cnt  <= 4'd0;
            ovf      <= 1'b0;
        end else begin
            p_d <= p;
            c_d <= c;
            if (p_req && !prod_take) begin
                if (prod_cnt == 2'd3) ovf      <= 1'b1;
                else                  prod_cnt <= prod_cnt + 2'd1;
            end else if (!p_req && prod_take) begin
                prod_cnt <= prod_cnt - 2'd1;
            end
            if (c_req && !chg_take) begin
                if (chg_cnt == 4'd15) ovf     <= 1'b1;
                else                  chg_cnt <= chg_cnt + 4'd1;
            end else if (!c_req && chg_take) begin
                chg_cnt <= chg_cnt - 4'd1;
            end
        end
    end

    assign busy  = (state != IDLE) || (prod_cnt != 2'd0) || (chg_cnt != 4'd0);
    assign fault = (state == FAULT);

endmodule
